// File: rtl/lsu_mem_ctrl.sv
// Handshaked data-memory stage behind the LSU.
// One request in flight; word RAM accessed after a fixed wait.
module lsu_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_idle;
  logic        w_write;
  logic [2:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_rel;
  logic [1:0]  w_unused_rel;
  logic [AW-1:0] w_idx;
  logic [1:0]  w_off;
  logic        w_size_bad;
  logic        w_misal;
  logic        w_range;
  logic        w_err;
  logic        w_acc;
  logic        w_we;
  logic [31:0] w_old;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_new;
  logic [31:0] w_rdata;

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle & ~rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // In IDLE the live request is used (LATENCY=0 accesses at accept).
  assign w_write = w_idle ? req_write : r_write;
  assign w_size  = w_idle ? req_size  : r_size;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;

  assign w_rel        = w_addr - BASE_ADDR;
  assign w_unused_rel = w_rel[1:0];
  assign w_idx        = w_rel[AW+1:2];
  assign w_off        = w_addr[1:0];
  assign w_range      = (w_rel >= SPAN);

  // Size legality and alignment
  always_comb begin
    w_size_bad = 1'b0;
    w_misal    = 1'b0;
    unique case (w_size)
      3'b000: w_size_bad = 1'b0;
      3'b001: w_misal = w_off[0];
      3'b010: w_misal = |w_off;
      3'b100: w_size_bad = w_write;
      3'b101: begin
        w_size_bad = w_write;
        w_misal    = w_off[0];
      end
      default: w_size_bad = 1'b1;
    endcase
  end

  assign w_err = w_size_bad | w_misal | w_range;

  assign w_acc = (w_idle && req_valid && (LATENCY == 0)) ||
                 (r_state == S_WAIT && r_cnt == 4'd1);
  assign w_we  = w_acc & w_write & ~w_err & ~rst;

  assign w_old  = r_mem[w_idx];
  assign w_byte = w_old[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_old[31:16] : w_old[15:0];

  // Load extraction with sign/zero extension
  always_comb begin
    w_load = w_old;
    unique case (w_size[1:0])
      2'b00:   w_load = {{24{~w_size[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~w_size[2] & w_half[15]}}, w_half};
      default: w_load = w_old;
    endcase
  end

  // Store merge into the old word by byte lanes
  always_comb begin
    w_new = w_old;
    unique case (w_size[1:0])
      2'b00: w_new[{w_off, 3'b000} +: 8] = w_wdata[7:0];
      2'b01: begin
        if (w_off[1]) w_new[31:16] = w_wdata[15:0];
        else          w_new[15:0]  = w_wdata[15:0];
      end
      default: w_new = w_wdata;
    endcase
  end

  assign w_rdata = (w_write | w_err) ? 32'd0 : w_load;

  // RAM write port, not reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= w_new;
  end

  // Control FSM with registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_size      <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY == 0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rdata;
              r_rsp_err   <= w_err;
            end else begin
              r_cnt   <= LAT4;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_err;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: vector table, scoreboard,
// backpressure and reset-abort sequences.
module tb_lsu_mem_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  lsu_mem_ctrl #(
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size (req_size),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic add(input logic wr, input logic [2:0] sz,
                     input logic [31:0] ad, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.sz = sz; v.ad = ad;
    v.wd = wd; v.er = er; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic [31:0] er, input logic ee);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    sb_q.push_back(e);
  endtask

  // Drive request, wait for accept, wait for response, pop and compare.
  task automatic do_req(input logic wr, input logic [2:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee,
                        input string nm);
    int n;
    exp_t e;
    push_exp(er, ee);
    @(negedge clk);
    req_write = wr;
    req_size  = sz;
    req_addr  = ad;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_to({nm, " accept"});
      req_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({nm, " busy"}, {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) begin
      fail_to({nm, " rsp"});
      void'(sb_q.pop_front());
      return;
    end
    chk({nm, " lat"}, 32'(n), 32'(LAT));
    e = sb_q.pop_front();
    chk({nm, " rdata"}, rsp_rdata, e.rdata);
    chk({nm, " err"}, {31'd0, rsp_err}, {31'd0, e.err});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({nm, " drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    exp_t e;
    logic [31:0] w0;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;

    // Reset state
    #1;
    chk("rst ready", {31'd0, req_ready}, 32'd0);
    chk("rst valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle ready", {31'd0, req_ready}, 32'd1);

    w0 = 32'hBEEF_78EF;

    add(1, 3'b010, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 0);
    add(0, 3'b010, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 0);
    add(0, 3'b000, 32'h8000_0003, 32'h0, 32'hFFFF_FFDE, 0);
    add(0, 3'b100, 32'h8000_0003, 32'h0, 32'h0000_00DE, 0);
    add(0, 3'b001, 32'h8000_0002, 32'h0, 32'hFFFF_DEAD, 0);
    add(0, 3'b101, 32'h8000_0002, 32'h0, 32'h0000_DEAD, 0);
    add(0, 3'b000, 32'h8000_0000, 32'h0, 32'hFFFF_FFEF, 0);
    add(1, 3'b000, 32'h8000_0001, 32'h1234_5678, 32'h0, 0);
    add(0, 3'b010, 32'h8000_0000, 32'h0, 32'hDEAD_78EF, 0);
    add(0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_0078, 0);
    add(1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 0);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);
    add(1, 3'b001, 32'h8000_0000, 32'h0000_CAFE, 32'h0, 0);
    add(0, 3'b010, 32'h8000_0000, 32'h0, 32'hBEEF_CAFE, 0);
    add(1, 3'b000, 32'h8000_0000, 32'h0000_00EF, 32'h0, 0);
    add(1, 3'b000, 32'h8000_0001, 32'h0000_0078, 32'h0, 0);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);
    add(0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 1);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);
    add(1, 3'b001, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 1);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);
    add(0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1);
    add(1, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);
    add(1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 1);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);
    add(1, 3'b010, 32'h8000_1000, 32'h5555_5555, 32'h0, 1);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);
    add(0, 3'b010, 32'h7FFF_FFFC, 32'h0, 32'h0, 1);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);
    add(1, 3'b010, 32'h8000_0FFC, 32'hA5A5_A5A5, 32'h0, 0);
    add(0, 3'b010, 32'h8000_0FFC, 32'h0, 32'hA5A5_A5A5, 0);
    add(0, 3'b101, 32'h8000_0FFE, 32'h0, 32'h0000_A5A5, 0);
    add(0, 3'b000, 32'h8000_0FFE, 32'h0, 32'hFFFF_FFA5, 0);
    add(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0);

    foreach (vecs[i])
      do_req(vecs[i].wr, vecs[i].sz, vecs[i].ad, vecs[i].wd,
             vecs[i].er, vecs[i].ee, $sformatf("v%0d", i));

    // Backpressure: response held, second request must not be taken.
    push_exp(w0, 1'b0);
    @(negedge clk);
    req_write = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h8000_0000;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_write = 1'b1;
    req_wdata = 32'h0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rsp_valid) fail_to("bp rsp");
    e = sb_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp rdata%0d", k), rsp_rdata, e.rdata);
      chk($sformatf("bp err%0d", k), {31'd0, rsp_err}, {31'd0, e.err});
      chk($sformatf("bp valid%0d", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp ready%0d", k), {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp drop", {31'd0, rsp_valid}, 32'd0);
    chk("bp idle", {31'd0, req_ready}, 32'd1);
    do_req(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0, "bp after");

    // Reset during WAIT drops the pending store.
    @(negedge clk);
    req_write = 1'b1;
    req_size  = 3'b010;
    req_addr  = 32'h8000_0000;
    req_wdata = 32'h1111_1111;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("ra wait", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ra valid", {31'd0, rsp_valid}, 32'd0);
    chk("ra ready", {31'd0, req_ready}, 32'd0);
    chk("ra rdata", rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    do_req(0, 3'b010, 32'h8000_0000, 32'h0, w0, 0, "ra after");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Multi-cycle data-memory controller directly downstream of the load/store unit. It accepts one load/store request at a time over a valid/ready handshake and performs it against an internal word-organised data RAM after a programmable wait latency. Load results come back sign- or zero-extended, and misaligned, out-of-range and illegal-size accesses are flagged. It replaces immediate DPI memory calls with a cycle-accurate, handshaked memory stage.

## Interface
- BASE_ADDR, 32'h8000_0000, byte address of RAM word 0
- DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two)
- LATENCY, 2, wait cycles between accept and access (0..15)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE with rst low
- req_write  in  1  1 = store, 0 = load
- req_size  in  3  funct3 encoding: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access rejected

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture write, size, addr and wdata, and compute err.
  - If LATENCY=0, perform the access at this edge and go to RESP. Otherwise load cnt=LATENCY and go to WAIT.
- WAIT:
  - cnt decrements each edge.
  - At the edge where cnt==1, perform the access and go to RESP.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are registered and held stable.
  - On rsp_valid&rsp_ready, go to IDLE.
- Request inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- err=1 when any of the following holds:
  - size is 011, 110 or 111;
  - size is a store with 1xx;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - (addr-BASE_ADDR), as a 32-bit unsigned value, is ≥ DEPTH_WORDS*4.
- Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. Byte offset = addr[1:0].
- Store, no error: read-modify-write with byte enables.
  - sb writes lane off with wdata[7:0].
  - sh writes lanes off and off+1 with wdata[15:0].
  - sw writes all four lanes.
  - rsp_rdata=0.
- Load, no error: extract from the stored word.
  - lb/lbu take byte[off].
  - lh/lhu take half[off[1]].
  - lw takes the whole word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Error: no RAM write, rsp_rdata=0, rsp_err=1.
- RAM contents are not reset and are undefined until written.

## Timing
- Accept edge E0 is the edge where req_valid&req_ready.
- The RAM access occurs at edge E_LATENCY, i.e. E0 when LATENCY=0.
- rsp_valid is high from just after E_LATENCY until the handshake edge.
- Minimum request-to-request spacing is LATENCY+2 cycles, because req_ready stays low in WAIT and RESP.
- rsp_valid, rsp_rdata and rsp_err are all registered outputs. req_ready is combinational from the state and rst.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0, req_ready=0 while rst is high.
- Reset asserted in WAIT or RESP aborts the operation immediately. A pending store in WAIT is dropped and the RAM is unchanged.
- A store that has already completed in RESP remains written.

## Test plan
- Reset, LATENCY=2, sw 0x8000_0000 with 0xDEADBEEF:
  - rsp_valid rises 2 cycles after accept, rdata=0, err=0.
  - A following lw of the same address returns 0xDEADBEEF.
- Loads from the same word:
  - lb 0x8000_0003 → 0xFFFFFFDE; lbu 0x8000_0003 → 0x000000DE.
  - lh 0x8000_0002 → 0xFFFFDEAD; lhu 0x8000_0002 → 0x0000DEAD.
  - lb 0x8000_0000 → 0xFFFFFFEF.
- sb 0x8000_0001 with wdata 0x12345678, then lw 0x8000_0000 → 0xDEAD78EF.
- Sub-word store, then lw 0x8000_0000 → 0xBEEF78EF, where the store is either:
  - sh 0x8000_0002 with 0x0000BEEF;
  - sh 0x8000_0000 with 0x0000CAFE, then sb 0x8000_0000 with 0xEF, sb 0x8000_0001 with 0x78.
- Error cases, each → err=1, rdata=0, and a subsequent lw 0x8000_0000 is unchanged:
  - lw 0x8000_0002;
  - sh 0x8000_0001;
  - size 011;
  - sw BASE_ADDR+DEPTH_WORDS*4;
  - lw 0x7FFF_FFFC.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles with req_valid=1 → rsp fields stable, req_ready=0, no second accept. Release → handshake, then IDLE.
  - Assert rst during WAIT of sw 0x8000_0000/0x11111111 → rsp_valid=0 immediately; after release, lw returns the old value.
